// File: rtl/ins_dec_pipe_if.sv
// Handshake and decoded-field bundle for the ins_dec_pipe decode stage.
// master = the surrounding pipeline, slave = the decode stage itself.
interface ins_dec_pipe_if #(
  parameter int unsigned DW  = 4,
  parameter int unsigned PCW = 4,
  parameter int unsigned RA  = 2,
  parameter int unsigned IW  = 11
);
  localparam int unsigned NREG = 1 << RA;

  logic            in_valid;
  logic [IW-1:0]   INS;
  logic            in_ready;
  logic            flush;
  logic            wb_valid;
  logic [RA-1:0]   WB_ADDR;
  logic            out_valid;
  logic            out_ready;
  logic            sel_data;
  logic            write_en;
  logic            alu_op;
  logic            is_branch;
  logic [RA-1:0]   SEL_A;
  logic [RA-1:0]   SEL_B;
  logic [RA-1:0]   SEL_W;
  logic [DW-1:0]   IMM;
  logic [PCW-1:0]  JMP;
  logic [NREG-1:0] PEND;

  modport master (
    output in_valid, INS, flush, wb_valid, WB_ADDR, out_ready,
    input  in_ready, out_valid, sel_data, write_en, alu_op, is_branch,
           SEL_A, SEL_B, SEL_W, IMM, JMP, PEND
  );

  modport slave (
    input  in_valid, INS, flush, wb_valid, WB_ADDR, out_ready,
    output in_ready, out_valid, sel_data, write_en, alu_op, is_branch,
           SEL_A, SEL_B, SEL_W, IMM, JMP, PEND
  );
endinterface

// File: rtl/ins_dec_pipe.sv
// One-entry instruction decode stage with valid/ready handshake and flush.
// Define INS_DEC_HAZARD_EN to add a pending-write scoreboard that stalls RAW hazards.
module ins_dec_pipe #(
  parameter int unsigned DW  = 4,
  parameter int unsigned PCW = 4,
  parameter int unsigned RA  = 2,
  parameter int unsigned IW  = 11
) (
  input  logic          clk,
  input  logic          rst,
  ins_dec_pipe_if.slave bus
);
  localparam int unsigned NREG = 1 << RA;
  localparam int unsigned FLDW = (DW + PCW > 3 * RA) ? (DW + PCW) : (3 * RA);

  if (IW < 3 + FLDW) begin : g_bad_iw
    $error("ins_dec_pipe: IW too small for opcode plus operand fields");
  end

  logic            out_valid_q;
  logic            sel_data_q, write_en_q, alu_op_q, is_branch_q;
  logic [RA-1:0]   sel_a_q, sel_b_q, sel_w_q;
  logic [DW-1:0]   imm_q;
  logic [PCW-1:0]  jmp_q;
  logic [NREG-1:0] pend_q, pend_d;

  logic [2:0] op_c;
  logic       hazard_c, in_ready_c, accept_c, issue_c;

  assign op_c       = bus.INS[IW-1 -: 3];
  assign in_ready_c = ~bus.flush & (~out_valid_q | bus.out_ready) & ~hazard_c;
  assign accept_c   = bus.in_valid & in_ready_c;
  assign issue_c    = out_valid_q & bus.out_ready & ~bus.flush;

`ifdef INS_DEC_HAZARD_EN
  // Stall when the incoming word reads a register still owed a write-back,
  // including the one the held instruction is about to issue.
  logic          reads_c, held_wr_c;
  logic [RA-1:0] ra_c, rb_c;
  assign reads_c   = ~op_c[1];
  assign ra_c      = bus.INS[2*RA-1:RA];
  assign rb_c      = bus.INS[RA-1:0];
  assign held_wr_c = out_valid_q & write_en_q;
  assign hazard_c  = reads_c & (pend_q[ra_c] | pend_q[rb_c] |
                                (held_wr_c & ((sel_w_q == ra_c) | (sel_w_q == rb_c))));

  // Set applied after clear so a same-cycle set/clear on one register leaves it set.
  always_comb begin
    pend_d = pend_q;
    if (bus.wb_valid) pend_d[bus.WB_ADDR] = 1'b0;
    if (issue_c && write_en_q) pend_d[sel_w_q] = 1'b1;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_valid, bus.WB_ADDR};
  assign hazard_c  = 1'b0;
  assign pend_d    = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sel_data_q  <= 1'b0;
      write_en_q  <= 1'b0;
      alu_op_q    <= 1'b0;
      is_branch_q <= 1'b0;
      sel_a_q     <= '0;
      sel_b_q     <= '0;
      sel_w_q     <= '0;
      imm_q       <= '0;
      jmp_q       <= '0;
      pend_q      <= '0;
    end else begin
      pend_q <= pend_d;
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (accept_c) begin
        out_valid_q <= 1'b1;
      end else if (issue_c) begin
        out_valid_q <= 1'b0;
      end
      if (accept_c) begin
        sel_data_q  <= op_c[1];
        alu_op_q    <= op_c[0];
        is_branch_q <= (op_c == 3'b100);
        write_en_q  <= ~((op_c == 3'b100) | (op_c == 3'b011));
        sel_b_q     <= bus.INS[RA-1:0];
        sel_a_q     <= bus.INS[2*RA-1:RA];
        sel_w_q     <= bus.INS[3*RA-1:2*RA];
        imm_q       <= bus.INS[DW-1:0];
        jmp_q       <= bus.INS[DW+PCW-1:DW];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_data  = sel_data_q;
  assign bus.write_en  = write_en_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.is_branch = is_branch_q;
  assign bus.SEL_A     = sel_a_q;
  assign bus.SEL_B     = sel_b_q;
  assign bus.SEL_W     = sel_w_q;
  assign bus.IMM       = imm_q;
  assign bus.JMP       = jmp_q;
  assign bus.PEND      = pend_q;
endmodule

// File: tb/tb_ins_dec_pipe.sv
// Randomised bench for ins_dec_pipe (defaults DW=4 PCW=4 RA=2 IW=11) against a
// transaction-level model of the decode stage; follows INS_DEC_HAZARD_EN like the design.
module tb_ins_dec_pipe;
  logic clk = 1'b0;
  logic rst;

  ins_dec_pipe_if #(.DW(4), .PCW(4), .RA(2), .IW(11)) bus ();

  ins_dec_pipe #(.DW(4), .PCW(4), .RA(2), .IW(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Model state: held instruction word, its decoded view, valid flag, scoreboard.
  logic        m_valid;
  logic [10:0] m_word;
  logic [17:0] m_fields;
  logic [3:0]  m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // {sel_data, write_en, alu_op, is_branch, SEL_A, SEL_B, SEL_W, IMM, JMP}
  function automatic logic [17:0] decode(input logic [10:0] w);
    logic [2:0] op;
    logic       br, we;
    op = w[10:8];
    br = (op == 3'b100);
    we = !(op == 3'b100 || op == 3'b011);
    return {op[1], we, op[0], br, w[3:2], w[1:0], w[5:4], w[3:0], w[7:4]};
  endfunction

  function automatic logic model_ready(input logic [10:0] w, input logic fl, input logic ordy);
    logic       haz;
    logic [1:0] a, b, hw;
    logic       hwe;
    a   = w[3:2];
    b   = w[1:0];
    hw  = m_word[5:4];
    hwe = decode(m_word)[16];
    haz = 1'b0;
`ifdef INS_DEC_HAZARD_EN
    if (w[9] == 1'b0)
      haz = m_pend[a] || m_pend[b] || (m_valid && hwe && (hw == a || hw == b));
`endif
    return !fl && (!m_valid || ordy) && !haz;
  endfunction

  task automatic cycle(input logic inv, input logic [10:0] ins, input logic fl,
                       input logic wbv, input logic [1:0] wba, input logic ordy,
                       input logic rs);
    logic exp_rdy, acc, iss;
    @(negedge clk);
    bus.in_valid  = inv;
    bus.INS       = ins;
    bus.flush     = fl;
    bus.wb_valid  = wbv;
    bus.WB_ADDR   = wba;
    bus.out_ready = ordy;
    rst           = rs;
    #1;
    exp_rdy = model_ready(ins, fl, ordy);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rs) begin
      m_valid  = 1'b0;
      m_word   = '0;
      m_fields = '0;
      m_pend   = '0;
    end else begin
      acc = inv && exp_rdy;
      iss = m_valid && ordy && !fl;
`ifdef INS_DEC_HAZARD_EN
      if (wbv) m_pend[wba] = 1'b0;
      if (iss && m_fields[16]) m_pend[m_word[5:4]] = 1'b1;
`endif
      if (fl) m_valid = 1'b0;
      else if (acc) begin
        m_valid  = 1'b1;
        m_word   = ins;
        m_fields = decode(ins);
      end else if (iss) m_valid = 1'b0;
    end
    #1;
    chk("outputs", 32'({bus.out_valid, bus.sel_data, bus.write_en, bus.alu_op, bus.is_branch,
                        bus.SEL_A, bus.SEL_B, bus.SEL_W, bus.IMM, bus.JMP}),
                   32'({m_valid, m_fields}));
    chk("pend", 32'(bus.PEND), 32'(m_pend));
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 11'h000, 1'b0, 1'b0, 2'd0, ordy, 1'b0);
  endtask

  initial begin
    logic [10:0] w;
    logic        fl, wbv;
    m_valid = 1'b0; m_word = '0; m_fields = '0; m_pend = '0;
    bus.in_valid = 1'b0; bus.INS = '0; bus.flush = 1'b0;
    bus.wb_valid = 1'b0; bus.WB_ADDR = '0; bus.out_ready = 1'b0;
    rst = 1'b1;

    cycle(1'b0, 11'h000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    cycle(1'b0, 11'h000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);

    // All-zero word: writes r0 via ALU path, every field zero.
    cycle(1'b1, 11'b00000000000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("zero_word", 32'({bus.out_valid, bus.write_en, bus.SEL_W, bus.IMM}), 32'({1'b1, 1'b1, 2'b00, 4'h0}));
    idle(1'b1);
    idle(1'b1);

    cycle(1'b1, 11'b10000000000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("branch", 32'({bus.write_en, bus.is_branch}), 32'({1'b0, 1'b1}));
    cycle(1'b1, 11'b01100000000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("noop", 32'({bus.write_en, bus.sel_data, bus.alu_op}), 32'({1'b0, 1'b1, 1'b1}));
    cycle(1'b1, 11'b11111111111, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("all_ones", 32'({bus.write_en, bus.SEL_A, bus.SEL_B, bus.SEL_W, bus.IMM, bus.JMP}),
                    32'({1'b1, 2'b11, 2'b11, 2'b11, 4'hF, 4'hF}));

    // Back-pressure: held word stays put for three cycles, then the next is taken.
    for (int i = 0; i < 3; i++) cycle(1'b1, 11'b01010100110, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("held_ones", 32'({bus.out_valid, bus.IMM, bus.JMP}), 32'({1'b1, 4'hF, 4'hF}));
    cycle(1'b1, 11'b01010100110, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("after_stall", 32'({bus.out_valid, bus.IMM}), 32'({1'b1, 4'h6}));

    // Flush drops the held word; flush together with reset resets.
    cycle(1'b1, 11'b11100000001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("flushed", 32'(bus.out_valid), 32'(1'b0));
    cycle(1'b1, 11'b11100000001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 11'b11100000001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1);

    // Scoreboard scenario: writer to r2 issues, then a reader of r2 arrives.
    cycle(1'b1, 11'b00000100000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(1'b1);
`ifdef INS_DEC_HAZARD_EN
    chk("pend_r2", 32'(bus.PEND), 32'(4'b0100));
`else
    chk("pend_off", 32'(bus.PEND), 32'(4'b0000));
`endif
    cycle(1'b1, 11'b00000001000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    cycle(1'b1, 11'b00000001000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    cycle(1'b1, 11'b00000001000, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
    cycle(1'b1, 11'b00000001000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("reader_in", 32'({bus.out_valid, bus.SEL_A, bus.PEND}), 32'({1'b1, 2'd2, 4'b0000}));

    // Reset while holding a word with the scoreboard populated.
    cycle(1'b1, 11'b00000110000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    cycle(1'b1, 11'b11111111111, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(1'b0);
    cycle(1'b1, 11'b11111111111, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("rst_mid", 32'({bus.out_valid, bus.PEND, bus.IMM, bus.write_en}), 32'(0));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      w   = 11'($urandom);
      fl  = ($urandom_range(0, 7) == 0);
      wbv = !fl && ($urandom_range(0, 2) == 0);
      cycle(1'($urandom_range(0, 9) < 7), w, fl, wbv, 2'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 79) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
